// File: rtl/alu_branch_pkg.sv
// Shared opcode encodings and width defaults for the execute-stage ALU/branch unit.
// Imported by alu_src_a_sel and alu_branch_unit.
package alu_branch_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int PC_W_DEF   = 32;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_NOR   = 4'b0100;
    localparam logic [3:0] ALU_SLL   = 4'b0101;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_SLTU  = 4'b1010;
    localparam logic [3:0] ALU_LUI   = 4'b1011;
    localparam logic [3:0] ALU_MULT  = 4'b1100;
    localparam logic [3:0] ALU_MULTU = 4'b1101;
    localparam logic [3:0] ALU_DIV   = 4'b1110;
    localparam logic [3:0] ALU_DIVU  = 4'b1111;

endpackage

// File: rtl/alu_src_a_sel.sv
// Operand-A mux: register rs value or zero-extended shift amount.
// Purely combinational.
module alu_src_a_sel
    import alu_branch_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] read_data1,
    input  logic [4:0]        shamt,
    input  logic              select_shamt,
    output logic [DATA_W-1:0] src_a
);

    // Pick shamt for immediate shifts, rs otherwise
    always_comb begin
        src_a = select_shamt ? {{(DATA_W-5){1'b0}}, shamt} : read_data1;
    end

endmodule

// File: rtl/alu_branch_unit.sv
// Execute stage: 32-bit ALU with hi/lo and flags, plus branch PC resolution.
// Define ALU_MULDIV_EN to build the multiplier/divider (opcodes 1100-1111).
module alu_branch_unit
    import alu_branch_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PC_W   = PC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_en,
    input  logic [3:0]        alu_control,
    input  logic [DATA_W-1:0] read_data1,
    input  logic [4:0]        shamt,
    input  logic              select_shamt,
    input  logic [DATA_W-1:0] alu_srcB,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              overflow,
    output logic              alu_zero,
    output logic              alu_done,
    input  logic              branch_en,
    input  logic              branch,
    input  logic [PC_W-1:0]   imm,
    input  logic [PC_W-1:0]   pc,
    output logic [PC_W-1:0]   pc_out,
    output logic              branch_done
);

    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic [4:0]        sa;
    logic [DATA_W-1:0] res_c, hi_c, lo_c;
    logic              ovf_c;

    logic [DATA_W-1:0] alu_result_q, alu_result_d;
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic              overflow_q, overflow_d;
    logic              alu_zero_q, alu_zero_d;
    logic              alu_done_q, alu_done_d;
    logic [PC_W-1:0]   pc_out_q, pc_out_d;
    logic              branch_done_q, branch_done_d;

`ifdef ALU_MULDIV_EN
    logic [2*DATA_W-1:0] prod_s;
    logic [2*DATA_W-1:0] prod_u;
`endif

    alu_src_a_sel #(.DATA_W(DATA_W)) u_src_a (
        .read_data1   (read_data1),
        .shamt        (shamt),
        .select_shamt (select_shamt),
        .src_a        (src_a)
    );

    assign sum  = src_a + alu_srcB;
    assign diff = src_a - alu_srcB;
    assign sa   = src_a[4:0];

`ifdef ALU_MULDIV_EN
    // Full-width products; the signed one uses sign-extended operands
    always_comb begin
        prod_s = {{DATA_W{src_a[DATA_W-1]}}, src_a}
               * {{DATA_W{alu_srcB[DATA_W-1]}}, alu_srcB};
        prod_u = {{DATA_W{1'b0}}, src_a} * {{DATA_W{1'b0}}, alu_srcB};
    end
`endif

    // ALU core: result, hi/lo candidates and signed overflow
    always_comb begin
        res_c = '0;
        hi_c  = hi_q;
        lo_c  = lo_q;
        ovf_c = 1'b0;
        case (alu_control)
            ALU_AND:  res_c = src_a & alu_srcB;
            ALU_OR:   res_c = src_a | alu_srcB;
            ALU_XOR:  res_c = src_a ^ alu_srcB;
            ALU_NOR:  res_c = ~(src_a | alu_srcB);
            ALU_ADD: begin
                res_c = sum;
                ovf_c = (src_a[DATA_W-1] == alu_srcB[DATA_W-1])
                     && (sum[DATA_W-1] != src_a[DATA_W-1]);
            end
            ALU_SUB: begin
                res_c = diff;
                ovf_c = (src_a[DATA_W-1] != alu_srcB[DATA_W-1])
                     && (diff[DATA_W-1] != src_a[DATA_W-1]);
            end
            ALU_SLL:  res_c = alu_srcB << sa;
            ALU_SRL:  res_c = alu_srcB >> sa;
            ALU_SRA:  res_c = $signed(alu_srcB) >>> sa;
            ALU_SLT:  res_c = {{(DATA_W-1){1'b0}},
                               $signed(src_a) < $signed(alu_srcB)};
            ALU_SLTU: res_c = {{(DATA_W-1){1'b0}}, src_a < alu_srcB};
            ALU_LUI:  res_c = alu_srcB << 16;
`ifdef ALU_MULDIV_EN
            ALU_MULT: begin
                {hi_c, lo_c} = prod_s;
                res_c = lo_c;
            end
            ALU_MULTU: begin
                {hi_c, lo_c} = prod_u;
                res_c = lo_c;
            end
            ALU_DIV: begin
                if (alu_srcB == '0) begin
                    lo_c = '1;
                    hi_c = src_a;
                end else begin
                    lo_c = $signed(src_a) / $signed(alu_srcB);
                    hi_c = $signed(src_a) % $signed(alu_srcB);
                end
                res_c = lo_c;
            end
            ALU_DIVU: begin
                if (alu_srcB == '0) begin
                    lo_c = '1;
                    hi_c = src_a;
                end else begin
                    lo_c = src_a / alu_srcB;
                    hi_c = src_a % alu_srcB;
                end
                res_c = lo_c;
            end
`endif
            default:  res_c = '0;
        endcase
    end

    // ALU handshake: capture once per request, done tracks alu_en
    always_comb begin
        alu_result_d = alu_result_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        overflow_d   = overflow_q;
        alu_zero_d   = alu_zero_q;
        alu_done_d   = alu_en;
        if (alu_en && !alu_done_q) begin
            alu_result_d = res_c;
            hi_d         = hi_c;
            lo_d         = lo_c;
            overflow_d   = ovf_c;
            alu_zero_d   = (res_c == '0);
        end
    end

    // Branch handshake: uses the already-registered zero flag
    always_comb begin
        pc_out_d      = pc_out_q;
        branch_done_d = branch_en;
        if (branch_en && !branch_done_q) begin
            pc_out_d = (branch && alu_zero_q) ? pc + imm : pc;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_result_q  <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            overflow_q    <= 1'b0;
            alu_zero_q    <= 1'b0;
            alu_done_q    <= 1'b0;
            pc_out_q      <= '0;
            branch_done_q <= 1'b0;
        end else begin
            alu_result_q  <= alu_result_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            overflow_q    <= overflow_d;
            alu_zero_q    <= alu_zero_d;
            alu_done_q    <= alu_done_d;
            pc_out_q      <= pc_out_d;
            branch_done_q <= branch_done_d;
        end
    end

    assign alu_result  = alu_result_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign overflow    = overflow_q;
    assign alu_zero    = alu_zero_q;
    assign alu_done    = alu_done_q;
    assign pc_out      = pc_out_q;
    assign branch_done = branch_done_q;

endmodule

// File: tb/tb_alu_branch_unit.sv
// Directed bench for alu_branch_unit: opcode table plus handshake,
// branch, mul/div and asynchronous reset sequences.
module tb_alu_branch_unit;
    import alu_branch_pkg::*;

    logic        clk;
    logic        rst;
    logic        alu_en;
    logic [3:0]  alu_control;
    logic [31:0] read_data1;
    logic [4:0]  shamt;
    logic        select_shamt;
    logic [31:0] alu_srcB;
    logic [31:0] alu_result, hi, lo;
    logic        overflow, alu_zero, alu_done;
    logic        branch_en, branch;
    logic [31:0] imm, pc, pc_out;
    logic        branch_done;

    int checks;
    int failures;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [4:0]  sh;
        logic        sel;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vecs[15];

    alu_branch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .alu_en       (alu_en),
        .alu_control  (alu_control),
        .read_data1   (read_data1),
        .shamt        (shamt),
        .select_shamt (select_shamt),
        .alu_srcB     (alu_srcB),
        .alu_result   (alu_result),
        .hi           (hi),
        .lo           (lo),
        .overflow     (overflow),
        .alu_zero     (alu_zero),
        .alu_done     (alu_done),
        .branch_en    (branch_en),
        .branch       (branch),
        .imm          (imm),
        .pc           (pc),
        .pc_out       (pc_out),
        .branch_done  (branch_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic [3:0] op, input logic [31:0] a,
                           input logic [4:0] sh, input logic sel,
                           input logic [31:0] b);
        alu_control  = op;
        read_data1   = a;
        shamt        = sh;
        select_shamt = sel;
        alu_srcB     = b;
    endtask

    // Request one ALU op and release the handshake
    task automatic run_alu(input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        set_alu(op, a, 5'd0, 1'b0, b);
        alu_en = 1'b1;
        step();
        alu_en = 1'b0;
        step();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        alu_en = 1'b0;
        branch_en = 1'b0;
        branch = 1'b0;
        imm = '0;
        pc = '0;
        set_alu(ALU_AND, '0, '0, 1'b0, '0);

        vecs[0]  = '{ALU_ADD,  32'h7FFFFFFF, 5'd0,  1'b0, 32'd1,
                     32'h80000000, 1'b1, 1'b0};
        vecs[1]  = '{ALU_SUB,  32'd5, 5'd0, 1'b0, 32'd5,
                     32'd0, 1'b0, 1'b1};
        vecs[2]  = '{ALU_SLL,  32'h0000FFFF, 5'd4, 1'b1, 32'h3,
                     32'h30, 1'b0, 1'b0};
        vecs[3]  = '{ALU_SRA,  32'd0, 5'd31, 1'b1, 32'h80000000,
                     32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[4]  = '{ALU_AND,  32'hF0F0, 5'd0, 1'b0, 32'hFF00,
                     32'hF000, 1'b0, 1'b0};
        vecs[5]  = '{ALU_OR,   32'hF0F0, 5'd0, 1'b0, 32'hFF00,
                     32'hFFF0, 1'b0, 1'b0};
        vecs[6]  = '{ALU_XOR,  32'hF0F0, 5'd0, 1'b0, 32'hFF00,
                     32'h0FF0, 1'b0, 1'b0};
        vecs[7]  = '{ALU_NOR,  32'd0, 5'd0, 1'b0, 32'd0,
                     32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[8]  = '{ALU_SRL,  32'hFFFFFFFF, 5'd4, 1'b1, 32'h80000000,
                     32'h08000000, 1'b0, 1'b0};
        vecs[9]  = '{ALU_SLT,  32'hFFFFFFFF, 5'd0, 1'b0, 32'd1,
                     32'd1, 1'b0, 1'b0};
        vecs[10] = '{ALU_SLTU, 32'hFFFFFFFF, 5'd0, 1'b0, 32'd1,
                     32'd0, 1'b0, 1'b1};
        vecs[11] = '{ALU_LUI,  32'd0, 5'd0, 1'b0, 32'h1234,
                     32'h12340000, 1'b0, 1'b0};
        vecs[12] = '{ALU_SUB,  32'h80000000, 5'd0, 1'b0, 32'd1,
                     32'h7FFFFFFF, 1'b1, 1'b0};
        vecs[13] = '{ALU_ADD,  32'hFFFFFFFF, 5'd0, 1'b0, 32'd1,
                     32'd0, 1'b0, 1'b1};
        vecs[14] = '{ALU_SLL,  32'h00000021, 5'd7, 1'b0, 32'd1,
                     32'd2, 1'b0, 1'b0};

        #12;
        check("reset_result", alu_result, 32'd0);
        check("reset_done", {31'd0, alu_done}, 32'd0);
        check("reset_pc_out", pc_out, 32'd0);
        check("reset_hi", hi, 32'd0);
        rst = 1'b0;
        step();

        foreach (vecs[i]) begin
            set_alu(vecs[i].op, vecs[i].a, vecs[i].sh, vecs[i].sel,
                    vecs[i].b);
            alu_en = 1'b1;
            step();
            check($sformatf("v%0d_done", i), {31'd0, alu_done}, 32'd1);
            check($sformatf("v%0d_res", i), alu_result, vecs[i].res);
            check($sformatf("v%0d_ovf", i), {31'd0, overflow},
                  {31'd0, vecs[i].ovf});
            check($sformatf("v%0d_zero", i), {31'd0, alu_zero},
                  {31'd0, vecs[i].zero});
            alu_en = 1'b0;
            step();
            check($sformatf("v%0d_drop", i), {31'd0, alu_done}, 32'd0);
            check($sformatf("v%0d_hold", i), alu_result, vecs[i].res);
        end

        // Held request must not recompute with new operands
        set_alu(ALU_SUB, 32'd5, 5'd0, 1'b0, 32'd5);
        alu_en = 1'b1;
        step();
        set_alu(ALU_ADD, 32'd1, 5'd0, 1'b0, 32'd1);
        step();
        check("hold_done", {31'd0, alu_done}, 32'd1);
        check("hold_res", alu_result, 32'd0);
        check("hold_zero", {31'd0, alu_zero}, 32'd1);
        alu_en = 1'b0;
        step();

        // Multiply / divide
        run_alu(ALU_MULT, 32'hFFFFFFFE, 32'd3);
`ifdef ALU_MULDIV_EN
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFFA);
        check("mult_res", alu_result, 32'hFFFFFFFA);
`else
        check("mult_hi", hi, 32'd0);
        check("mult_lo", lo, 32'd0);
        check("mult_res", alu_result, 32'd0);
`endif
        run_alu(ALU_DIVU, 32'd7, 32'd0);
`ifdef ALU_MULDIV_EN
        check("divu0_lo", lo, 32'hFFFFFFFF);
        check("divu0_hi", hi, 32'd7);
`else
        check("divu0_lo", lo, 32'd0);
        check("divu0_hi", hi, 32'd0);
`endif
        run_alu(ALU_DIV, 32'd7, 32'hFFFFFFFE);
`ifdef ALU_MULDIV_EN
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'd1);
`else
        check("div_lo", lo, 32'd0);
        check("div_hi", hi, 32'd0);
`endif
        check("muldiv_ovf", {31'd0, overflow}, 32'd0);
        // Plain op after mul/div leaves hi/lo alone
        run_alu(ALU_ADD, 32'd2, 32'd3);
`ifdef ALU_MULDIV_EN
        check("keep_lo", lo, 32'hFFFFFFFD);
`else
        check("keep_lo", lo, 32'd0);
`endif

        // Branch taken with zero flag set
        run_alu(ALU_SUB, 32'd5, 32'd5);
        branch = 1'b1;
        pc = 32'd10;
        imm = 32'hFFFFFFFD;
        branch_en = 1'b1;
        step();
        check("br_taken_done", {31'd0, branch_done}, 32'd1);
        check("br_taken_pc", pc_out, 32'd7);
        pc = 32'd50;
        step();
        check("br_hold_pc", pc_out, 32'd7);
        branch_en = 1'b0;
        step();
        check("br_drop", {31'd0, branch_done}, 32'd0);

        // Not a branch instruction: fall through even with zero set
        branch = 1'b0;
        pc = 32'd10;
        branch_en = 1'b1;
        step();
        check("br_nobranch_pc", pc_out, 32'd10);
        branch_en = 1'b0;
        step();

        // Zero flag clear: not taken
        run_alu(ALU_ADD, 32'd1, 32'd1);
        branch = 1'b1;
        branch_en = 1'b1;
        pc = 32'd20;
        step();
        check("br_nt_pc", pc_out, 32'd20);
        branch_en = 1'b0;
        step();

        // Same edge: branch sees old (clear) zero flag
        set_alu(ALU_SUB, 32'd9, 5'd0, 1'b0, 32'd9);
        alu_en = 1'b1;
        branch_en = 1'b1;
        pc = 32'd30;
        step();
        check("same_edge_pc", pc_out, 32'd30);
        check("same_edge_zero", {31'd0, alu_zero}, 32'd1);
        alu_en = 1'b0;
        branch_en = 1'b0;
        step();

        // Async reset in the middle of a held handshake
        set_alu(ALU_ADD, 32'd1, 5'd0, 1'b0, 32'd1);
        alu_en = 1'b1;
        branch_en = 1'b1;
        step();
        check("pre_rst_done", {31'd0, alu_done}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_done", {31'd0, alu_done}, 32'd0);
        check("arst_res", alu_result, 32'd0);
        check("arst_bdone", {31'd0, branch_done}, 32'd0);
        check("arst_pc", pc_out, 32'd0);
        check("arst_lo", lo, 32'd0);
        #10;
        rst = 1'b0;
        branch_en = 1'b0;
        step();
        check("post_rst_done", {31'd0, alu_done}, 32'd1);
        check("post_rst_res", alu_result, 32'd2);
        alu_en = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_branch_unit.md
Name: alu_branch_unit

Overview:
- Execute-stage block of the multi-cycle MIPS core.
- Selects ALU operand A (register rs value or zero-extended shamt) and runs a 32-bit ALU with hi/lo, overflow and zero flags.
- Resolves conditional branches into the next PC.
- ALU and branch each have an en/done handshake sequenced by the control FSM.

Parameters:
- DATA_W, 32, datapath width of operands, result, hi and lo.
- PC_W, 32, program counter width; PC is word-addressed.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- alu_en  in  1  ALU request; held high until alu_done is seen.
- alu_control  in  4  operation code.
- read_data1  in  DATA_W  rs register value.
- shamt  in  5  shift amount from the instruction.
- select_shamt  in  1  1: operand A = {27'b0, shamt}; 0: operand A = read_data1.
- alu_srcB  in  DATA_W  operand B (rt value or extended immediate, muxed upstream).
- alu_result  out  DATA_W  registered result.
- hi  out  DATA_W  registered multiply/divide high word.
- lo  out  DATA_W  registered multiply/divide low word.
- overflow  out  1  registered signed overflow flag.
- alu_zero  out  1  registered, alu_result==0.
- alu_done  out  1  ALU completion flag.
- branch_en  in  1  branch request; held until branch_done.
- branch  in  1  instruction is a taken-if-zero branch.
- imm  in  PC_W  sign-extended word offset.
- pc  in  PC_W  already-incremented PC (PC+1).
- pc_out  out  PC_W  registered next PC.
- branch_done  out  1  branch completion flag.

Behaviour:
- Reset (async): alu_result, hi, lo, overflow, alu_zero, alu_done, pc_out, branch_done all go to 0.
- Operand A mux is combinational: A = select_shamt ? zero-extended shamt : read_data1.
- ALU handshake:
  - Edge with alu_en=1 and alu_done=0: compute, register every ALU output, set alu_done=1. Latency is one edge.
  - alu_en=1 and alu_done=1: hold all outputs; no recompute.
  - alu_en=0: alu_done cleared next edge; results hold their values.
- Opcodes (A=srcA, B=alu_srcB):
  - 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0100 NOR; 0110 SUB.
  - 0101 SLL: B << A[4:0]. 1000 SRL: B >> A[4:0] logical. 1001 SRA: B >>> A[4:0] arithmetic.
  - 0111 SLT: signed A<B gives 1, else 0. 1010 SLTU: unsigned compare.
  - 1011 LUI: B << 16.
  - 1100 MULT / 1101 MULTU: signed/unsigned 64-bit product; {hi,lo} = product.
  - 1110 DIV / 1111 DIVU: lo = quotient, hi = remainder. Divide by zero: lo = all ones, hi = A.
  - For 1100-1111, alu_result = new lo. For all other ops, hi and lo hold.
- overflow: signed overflow for ADD/SUB only, 0 for all other ops. Result wraps mod 2^32 regardless.
- alu_zero: registered together with alu_result.
- Branch handshake: same protocol as the ALU on branch_en/branch_done.
  - pc_out = (branch && alu_zero) ? pc + imm : pc, computed mod 2^PC_W.
  - Uses the registered alu_zero value present before the edge.
  - alu_en and branch_en high on the same edge: the branch sees the previous alu_zero.
- Reset mid-handshake: both done flags drop immediately; the requester must re-assert en.

Optional Feature:
- Macro ALU_MULDIV_EN.
- Defined: opcodes 1100-1111 implemented as above.
- Undefined: no multiplier/divider is synthesised. Those opcodes give alu_result=0 and overflow=0, hi/lo stay at reset 0, and alu_done follows the normal handshake.

Decomposition:
- Package alu_branch_pkg: 4-bit opcode localparams (ALU_AND ... ALU_DIVU), DATA_W/PC_W defaults.
- One natural sub-module: alu_src_a_sel, the combinational operand-A mux.
- Branch logic and ALU core stay inline in the top.

Test Plan:
- ADD: A=32'h7FFFFFFF, B=1, select_shamt=0, alu_en=1 -> one edge later alu_done=1, result 32'h80000000, overflow=1, alu_zero=0.
- SUB to zero: A=5, B=5 -> result 0, alu_zero=1. Then alu_en=0 -> alu_done=0 next edge, result held at 0.
- SLL via shamt: shamt=4, select_shamt=1, read_data1=32'hFFFF, B=32'h3, op 0101 -> result 32'h30. SRA with B=32'h80000000, shamt=31 -> 32'hFFFFFFFF.
- MULT (ALU_MULDIV_EN defined): A=-2, B=3 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFFA. DIVU 7/0 -> lo=32'hFFFFFFFF, hi=7.
- Branch: alu_zero=1, branch=1, pc=10, imm=-3, branch_en=1 -> branch_done=1, pc_out=7. Same with alu_zero=0 -> pc_out=10.
- Reset asserted while alu_en and alu_done are both 1 -> all outputs 0 asynchronously. After release with alu_en still 1 -> recompute, alu_done=1 one edge later.
